multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RISC-V style datapath. It sequences fetch, decode,
// execute, memory and write-back, with memory wait timeout, stall freeze and trap.
module multicycle_control #(
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int EN_JAL      = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [6:0]         i_OPCode,
  input  logic               i_mem_ready,
  input  logic               i_stall,
  input  logic               i_trap_clr,
  output logic               o_PCWrite,
  output logic               o_Branch,
  output logic               o_IRWrite,
  output logic               o_MemRead,
  output logic               o_MemWrite,
  output logic               o_IorD,
  output logic               o_MemToReg,
  output logic               o_ALUSrcA,
  output logic               o_RegWrite,
  output logic               o_PCSource,
  output logic               o_trap,
  output logic [1:0]         o_ALUSrcB,
  output logic [ALUOP_W-1:0] o_ALUOp,
  output logic [3:0]         o_state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_LOAD_WB  = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t     r_state;
  logic [7:0] r_wait;
  logic [6:0] r_opcode;
  logic       r_run;

  state_t     w_next;
  logic [7:0] w_wait_inc;
  logic       w_at_limit;
  logic       w_wait_state;
  logic       w_hold;
  logic [1:0] w_aluop;

  assign w_wait_inc   = r_wait + 8'd1;
  // The cycle that would bring the counter up to MEM_TIMEOUT is the last wait allowed.
  assign w_at_limit   = (w_wait_inc == 8'(MEM_TIMEOUT));
  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                        (r_state == S_MEM_WR);
  assign w_hold       = i_stall && (r_state != S_TRAP);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (i_mem_ready)     w_next = S_DECODE;
        else if (w_at_limit) w_next = S_TRAP;
      end
      S_DECODE: begin
        case (i_OPCode)
          OP_RTYPE:          w_next = S_EXEC_R;
          OP_ITYPE:          w_next = S_EXEC_I;
          OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = (EN_JAL != 0) ? S_JAL : S_TRAP;
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: w_next = (r_opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (i_mem_ready)     w_next = S_LOAD_WB;
        else if (w_at_limit) w_next = S_TRAP;
      end
      S_LOAD_WB: w_next = S_FETCH;
      S_MEM_WR: begin
        if (i_mem_ready)     w_next = S_FETCH;
        else if (w_at_limit) w_next = S_TRAP;
      end
      S_EXEC_R:  w_next = S_ALU_WB;
      S_EXEC_I:  w_next = S_ALU_WB;
      S_ALU_WB:  w_next = S_FETCH;
      S_BRANCH:  w_next = S_FETCH;
      S_JAL:     w_next = S_FETCH;
      S_TRAP:    w_next = i_trap_clr ? S_FETCH : S_TRAP;
      default:   w_next = S_TRAP;
    endcase
  end

  // r_run stays low for the first edge after reset release so nothing is
  // issued (or advanced) while the outputs are still suppressed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_FETCH;
      r_wait   <= 8'd0;
      r_opcode <= 7'b0000000;
      r_run    <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (r_run && !w_hold) begin
        r_state <= w_next;
        if (w_next != r_state)
          r_wait <= 8'd0;
        else if (w_wait_state && !i_mem_ready)
          r_wait <= w_wait_inc;
        if (r_state == S_DECODE)
          r_opcode <= i_OPCode;
      end
    end
  end

  always_comb begin
    o_PCWrite  = 1'b0;
    o_Branch   = 1'b0;
    o_IRWrite  = 1'b0;
    o_MemRead  = 1'b0;
    o_MemWrite = 1'b0;
    o_IorD     = 1'b0;
    o_MemToReg = 1'b0;
    o_ALUSrcA  = 1'b0;
    o_RegWrite = 1'b0;
    o_PCSource = 1'b0;
    o_trap     = 1'b0;
    o_ALUSrcB  = 2'b00;
    w_aluop    = 2'b00;
    if (r_run) begin
      case (r_state)
        S_FETCH: begin
          o_MemRead = 1'b1;
          o_IRWrite = i_mem_ready;
          o_PCWrite = i_mem_ready;
          o_ALUSrcB = 2'b01;
        end
        S_DECODE: o_ALUSrcB = 2'b10;
        S_MEM_ADDR: begin
          o_ALUSrcA = 1'b1;
          o_ALUSrcB = 2'b10;
        end
        S_MEM_RD: begin
          o_MemRead = 1'b1;
          o_IorD    = 1'b1;
        end
        S_LOAD_WB: begin
          o_RegWrite = 1'b1;
          o_MemToReg = 1'b1;
        end
        S_MEM_WR: begin
          o_MemWrite = 1'b1;
          o_IorD     = 1'b1;
        end
        S_EXEC_R: begin
          o_ALUSrcA = 1'b1;
          w_aluop   = 2'b10;
        end
        S_EXEC_I: begin
          o_ALUSrcA = 1'b1;
          o_ALUSrcB = 2'b10;
          w_aluop   = 2'b11;
        end
        S_ALU_WB: o_RegWrite = 1'b1;
        S_BRANCH: begin
          o_Branch   = 1'b1;
          o_ALUSrcA  = 1'b1;
          o_PCSource = 1'b1;
          w_aluop    = 2'b01;
        end
        S_JAL: begin
          o_PCWrite  = 1'b1;
          o_PCSource = 1'b1;
          o_RegWrite = 1'b1;
        end
        S_TRAP:  o_trap = 1'b1;
        default: o_trap = 1'b0;
      endcase
    end
    // A stalled cycle must not commit any architectural state.
    if (w_hold) begin
      o_PCWrite  = 1'b0;
      o_IRWrite  = 1'b0;
      o_RegWrite = 1'b0;
      o_MemWrite = 1'b0;
    end
  end

  assign o_ALUOp = ALUOP_W'(w_aluop);
  assign o_state = r_state;

endmodule
